// File: rtl/rs_sd_loader.sv
// RS-232 (8N1) byte receiver feeding the sd_cont sector buffer: bytes are packed
// into 512-byte sectors and each full sector is committed with a write-back command.
module rs_sd_loader #(
  parameter logic [15:0] wtime        = 16'h0242,
  parameter logic [22:0] start_sector = 23'h0,
  parameter logic [22:0] nsectors     = 23'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [22:0] sd_addr,
  output logic [7:0]  sd_write_data,
  output logic        sd_write_enable,
  output logic [8:0]  sd_index,
  output logic        sd_write,
  input  logic        sd_busy,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        done,
  output logic [2:0]  rx_state,
  output logic [2:0]  ld_state
);

  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_START = 3'd1;
  localparam logic [2:0] R_DATA  = 3'd2;
  localparam logic [2:0] R_STOP  = 3'd3;
  localparam logic [2:0] R_BREAK = 3'd4;

  localparam logic [2:0] L_FILL    = 3'd0;
  localparam logic [2:0] L_FLUSH   = 3'd1;
  localparam logic [2:0] L_WAIT_HI = 3'd2;
  localparam logic [2:0] L_WAIT_LO = 3'd3;
  localparam logic [2:0] L_DONE    = 3'd4;

  // Timer reloads are one less than the period because expiry is the cycle at 0.
  localparam logic [15:0] half_load = (wtime >> 1) - 16'd1;
  localparam logic [15:0] bit_load  = wtime - 16'd1;

  logic        rx_meta;
  logic        rx_s;
  logic [15:0] bit_timer;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [8:0]  byte_cnt;
  logic [22:0] sector_cnt;
  logic [22:0] sector_cnt_nxt;
  logic        ld_draining;

  assign sector_cnt_nxt = sector_cnt + 23'd1;
  assign ld_draining    = (ld_state == L_FLUSH) || (ld_state == L_WAIT_HI) ||
                          (ld_state == L_WAIT_LO);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver: start bit is re-checked at mid-bit, data bits are sampled at bit centres.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= R_IDLE;
      bit_timer <= 16'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (!rx_s) begin
            bit_timer <= half_load;
            rx_state  <= R_START;
          end
        end
        R_START: begin
          if (bit_timer != 16'd0) begin
            bit_timer <= bit_timer - 16'd1;
          end else if (!rx_s) begin
            bit_timer <= bit_load;
            bit_cnt   <= 3'd0;
            rx_state  <= R_DATA;
          end else begin
            rx_state <= R_IDLE;
          end
        end
        R_DATA: begin
          if (bit_timer != 16'd0) begin
            bit_timer <= bit_timer - 16'd1;
          end else begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_timer <= bit_load;
            if (bit_cnt == 3'd7) begin
              rx_state <= R_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        R_STOP: begin
          if (bit_timer != 16'd0) begin
            bit_timer <= bit_timer - 16'd1;
          end else if (rx_s) begin
            rx_data  <= shift_reg;
            rx_valid <= 1'b1;
            rx_state <= R_IDLE;
          end else begin
            frame_err <= 1'b1;
            rx_state  <= R_BREAK;
          end
        end
        R_BREAK: begin
          if (rx_s) begin
            rx_state <= R_IDLE;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Write-back handshake: sd_write is a single-cycle request; sd_cont acknowledges
  // by raising sd_busy, and the sector is committed once sd_busy drops again.
  // sd_addr only advances after that, so it is stable for the whole exchange.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state        <= L_FILL;
      byte_cnt        <= 9'd0;
      sector_cnt      <= 23'd0;
      sd_addr         <= start_sector;
      sd_index        <= 9'd0;
      sd_write_data   <= 8'd0;
      sd_write_enable <= 1'b0;
      sd_write        <= 1'b0;
      overrun         <= 1'b0;
      done            <= 1'b0;
    end else begin
      sd_write_enable <= 1'b0;
      sd_write        <= 1'b0;
      if (rx_valid && ld_draining) begin
        overrun <= 1'b1;
      end
      case (ld_state)
        L_FILL: begin
          if (rx_valid) begin
            sd_write_data   <= rx_data;
            sd_index        <= byte_cnt;
            sd_write_enable <= 1'b1;
            if (byte_cnt == 9'd511) begin
              ld_state <= L_FLUSH;
            end else begin
              byte_cnt <= byte_cnt + 9'd1;
            end
          end
        end
        L_FLUSH: begin
          sd_write <= 1'b1;
          ld_state <= L_WAIT_HI;
        end
        L_WAIT_HI: begin
          if (sd_busy) begin
            ld_state <= L_WAIT_LO;
          end
        end
        L_WAIT_LO: begin
          if (!sd_busy) begin
            sector_cnt <= sector_cnt_nxt;
            sd_addr    <= sd_addr + 23'd1;
            byte_cnt   <= 9'd0;
            if (sector_cnt_nxt == nsectors) begin
              done     <= 1'b1;
              ld_state <= L_DONE;
            end else begin
              ld_state <= L_FILL;
            end
          end
        end
        L_DONE: begin
          done <= 1'b1;
        end
        default: ld_state <= L_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_sd_loader.sv
// Bench for rs_sd_loader: serial bytes are driven onto rx, every expected buffer
// write and write-back is queued at drive time and checked when the DUT emits it.
module tb_rs_sd_loader;

  localparam logic [15:0] WTIME = 16'd4;
  localparam logic [2:0]  R_IDLE    = 3'd0;
  localparam logic [2:0]  L_FILL    = 3'd0;
  localparam logic [2:0]  L_WAIT_LO = 3'd3;
  localparam logic [2:0]  L_DONE    = 3'd4;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [22:0] sd_addr;
  logic [7:0]  sd_write_data;
  logic        sd_write_enable;
  logic [8:0]  sd_index;
  logic        sd_write;
  logic        sd_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic        done;
  logic [2:0]  rx_state;
  logic [2:0]  ld_state;

  rs_sd_loader #(
    .wtime(WTIME),
    .start_sector(23'h0),
    .nsectors(23'h2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .sd_addr(sd_addr),
    .sd_write_data(sd_write_data),
    .sd_write_enable(sd_write_enable),
    .sd_index(sd_index),
    .sd_write(sd_write),
    .sd_busy(sd_busy),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .overrun(overrun),
    .done(done),
    .rx_state(rx_state),
    .ld_state(ld_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int wb_cnt = 0;
  int rx_valid_cnt = 0;
  int exp_rx_cnt = 0;
  int fe_cnt = 0;
  int busy_falls = 0;
  int busy_hold = 100;
  logic rv_prev = 1'b0;

  logic [39:0] exp_q[$];
  logic [22:0] exp_wb_q[$];
  logic [22:0] exp_addr;
  logic [8:0]  exp_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard side: compare emitted writes against the expected queues
  always @(negedge clk) begin
    if (sd_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_spurious", 64'(sd_write_enable), 64'd0);
      end else begin
        check("wr", {24'd0, sd_addr, sd_index, sd_write_data}, {24'd0, exp_q.pop_front()});
        check("wr_lat", 64'(rv_prev), 64'd1);
      end
      last_we_cyc = cyc;
    end
    if (sd_write === 1'b1) begin
      if (exp_wb_q.size() == 0) begin
        check("wb_spurious", 64'(sd_write), 64'd0);
      end else begin
        check("wb_addr", 64'(sd_addr), 64'(exp_wb_q.pop_front()));
        check("wb_lat", 64'(cyc - last_we_cyc), 64'd1);
      end
      wb_cnt++;
    end
    if (rx_valid === 1'b1) rx_valid_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    rv_prev = rx_valid;
  end

  // sd_cont busy model: busy 3 cycles after a write-back, held for busy_hold cycles
  initial begin
    sd_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (sd_write === 1'b1) begin
        repeat (3) @(posedge clk);
        #1 sd_busy = 1'b1;
        repeat (busy_hold) @(posedge clk);
        #1 sd_busy = 1'b0;
        busy_falls++;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      tick(int'(WTIME));
    end
    rx = 1'b1;
    tick(int'(WTIME));
    if (stop_ok) exp_rx_cnt++;
  endtask

  task automatic load_byte(input logic [7:0] d);
    exp_q.push_back({exp_addr, exp_idx, d});
    exp_idx = exp_idx + 9'd1;
    send_byte(d, 1'b1);
  endtask

  task automatic check_reset_vals();
    check("rst_addr", 64'(sd_addr), 64'd0);
    check("rst_index", 64'(sd_index), 64'd0);
    check("rst_wdata", 64'(sd_write_data), 64'd0);
    check("rst_rxdata", 64'(rx_data), 64'd0);
    check("rst_strobes", {59'd0, sd_write_enable, sd_write, rx_valid, frame_err, 1'b0}, 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rx_state", 64'(rx_state), 64'(R_IDLE));
    check("rst_ld_state", 64'(ld_state), 64'(L_FILL));
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    exp_addr = 23'd0;
    exp_idx = 9'd0;
    tick(4);
    check_reset_vals();
    rst = 1'b0;
    tick(4);

    // short low glitch, shorter than half a bit
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    check("glitch_rx_valid", 64'(rx_valid_cnt), 64'd0);
    check("glitch_frame_err", 64'(fe_cnt), 64'd0);
    check("glitch_rx_state", 64'(rx_state), 64'(R_IDLE));

    // bad stop bit discards 0xA5, then 0x3C lands at index 0
    send_byte(8'hA5, 1'b0);
    tick(4);
    check("fe_count", 64'(fe_cnt), 64'd1);
    load_byte(8'h3C);
    check("fe_rx_data", 64'(rx_data), 64'h3C);
    for (int i = 1; i < 100; i++) load_byte(8'($urandom_range(0, 255)));

    // reset in the middle of a sector
    tick(2);
    rst = 1'b1;
    tick(2);
    check_reset_vals();
    check("midrst_no_wb", 64'(wb_cnt), 64'd0);
    rst = 1'b0;
    exp_addr = 23'd0;
    exp_idx = 9'd0;
    tick(4);

    // sector 0: bytes 0x00..0xFF twice; long busy window for the overrun probe
    busy_hold = 300;
    exp_wb_q.push_back(23'd0);
    for (int i = 0; i < 512; i++) load_byte(8'(i));
    for (int k = 0; k < 60 && ld_state != L_WAIT_LO; k++) tick(1);
    check("s0_wait_lo", 64'(ld_state), 64'(L_WAIT_LO));
    send_byte(8'h77, 1'b1);
    tick(2);
    check("overrun_set", 64'(overrun), 64'd1);
    check("overrun_in_wait_lo", 64'(ld_state), 64'(L_WAIT_LO));
    check("s0_wb_done", 64'(wb_cnt), 64'd1);
    for (int k = 0; k < 400 && busy_falls < 1; k++) tick(1);
    check("s0_busy_fall", 64'(busy_falls), 64'd1);
    tick(2);
    check("s0_not_done", 64'(done), 64'd0);

    // sector 1 at address 1, index restarts at 0
    busy_hold = 100;
    exp_addr = 23'd1;
    exp_idx = 9'd0;
    exp_wb_q.push_back(23'd1);
    for (int i = 0; i < 512; i++) load_byte(8'($urandom_range(0, 255)));
    for (int k = 0; k < 60 && sd_busy !== 1'b1; k++) tick(1);
    check("s1_busy_hi", 64'(sd_busy), 64'd1);
    check("s1_done_early", 64'(done), 64'd0);
    for (int k = 0; k < 200 && busy_falls < 2; k++) tick(1);
    check("s1_busy_fall", 64'(busy_falls), 64'd2);
    tick(3);
    check("done_set", 64'(done), 64'd1);
    check("done_state", 64'(ld_state), 64'(L_DONE));

    // bytes after done are received but not written
    send_byte(8'h5A, 1'b1);
    tick(2);
    check("done_rx_data", 64'(rx_data), 64'h5A);
    check("done_hold", 64'(done), 64'd1);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // reset clears done and overrun; next byte goes to start_sector, index 0
    rst = 1'b1;
    tick(2);
    check_reset_vals();
    rst = 1'b0;
    exp_addr = 23'd0;
    exp_idx = 9'd0;
    tick(4);
    load_byte(8'hC3);
    tick(4);

    // final report
    check("wr_queue_empty", 64'(exp_q.size()), 64'd0);
    check("wb_queue_empty", 64'(exp_wb_q.size()), 64'd0);
    check("wb_total", 64'(wb_cnt), 64'd2);
    check("rx_valid_total", 64'(rx_valid_cnt), 64'(exp_rx_cnt));
    check("fe_total", 64'(fe_cnt), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
